countdown_timer: RTL

- Down-counting companion to the stopwatch: a preset value 00–59 s is loaded and counted down once per second while `start` is held high.
- Pauses when `start` drops.
- Emits a one-cycle `done` pulse and holds an `expired` flag on reaching 00.
- Outputs use the same BCD digit format (ones 0–9, tens 0–5) as the stopwatch, so the same 7-segment display path can drive either block.

---
 rtl/countdown_timer.sv | 122 ++++++++++++
 1 files changed

// File: rtl/countdown_timer.sv
// Seconds countdown timer (00-59, BCD digits) with pause, one-cycle done pulse
// and a sticky expired flag; CLK_FREQ clock cycles make one second.
module countdown_timer #(
   parameter int CLK_FREQ = 100_000_000
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       load,
   input  logic [3:0] set_1s,
   input  logic [2:0] set_10s,
   input  logic       start,
   output logic [3:0] NUM_1s,
   output logic [2:0] NUM_10s,
   output logic       running,
   output logic       done,
   output logic       expired
);

   localparam int PW = $clog2(CLK_FREQ);
   localparam logic [PW-1:0] TICK_LAST = PW'(CLK_FREQ - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      PAUSE   = 2'd2,
      EXPIRED = 2'd3
   } state_t;

   state_t          state_r;
   logic [PW-1:0]   presc_r;
   logic            tick_s;
   logic            last_s;
   logic            nonzero_s;

   function automatic logic [3:0] clamp_ones(input logic [3:0] v);
      return (v > 4'd9) ? 4'd9 : v;
   endfunction

   function automatic logic [2:0] clamp_tens(input logic [2:0] v);
      return (v > 3'd5) ? 3'd5 : v;
   endfunction

   assign tick_s    = (presc_r == TICK_LAST);
   assign last_s    = (NUM_1s == 4'd1) && (NUM_10s == 3'd0);
   assign nonzero_s = (NUM_1s != 4'd0) || (NUM_10s != 3'd0);

   // Timer state machine: reset, then load, then per-state behaviour.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_r <= IDLE;
         presc_r <= '0;
         NUM_1s  <= 4'd0;
         NUM_10s <= 3'd0;
         running <= 1'b0;
         done    <= 1'b0;
         expired <= 1'b0;
      end else if (load) begin
         state_r <= IDLE;
         presc_r <= '0;
         NUM_1s  <= clamp_ones(set_1s);
         NUM_10s <= clamp_tens(set_10s);
         running <= 1'b0;
         done    <= 1'b0;
         expired <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_r)
            IDLE: begin
               if (start && nonzero_s) begin
                  state_r <= RUN;
                  running <= 1'b1;
               end
            end
            RUN: begin
               // A tick due on this edge is honoured even if start just dropped.
               if (tick_s) begin
                  presc_r <= '0;
                  if (last_s) begin
                     NUM_1s  <= 4'd0;
                     state_r <= EXPIRED;
                     running <= 1'b0;
                     expired <= 1'b1;
                     done    <= 1'b1;
                  end else begin
                     if (NUM_1s != 4'd0) begin
                        NUM_1s <= NUM_1s - 4'd1;
                     end else begin
                        NUM_1s  <= 4'd9;
                        NUM_10s <= NUM_10s - 3'd1;
                     end
                     if (!start) begin
                        state_r <= PAUSE;
                        running <= 1'b0;
                     end
                  end
               end else if (start) begin
                  presc_r <= presc_r + PW'(1);
               end else begin
                  state_r <= PAUSE;
                  running <= 1'b0;
               end
            end
            PAUSE: begin
               if (start) begin
                  state_r <= RUN;
                  running <= 1'b1;
               end
            end
            EXPIRED: begin
               NUM_1s  <= 4'd0;
               NUM_10s <= 3'd0;
            end
            default: begin
               state_r <= IDLE;
               running <= 1'b0;
               expired <= 1'b0;
            end
         endcase
      end
   end

endmodule
